// File: rtl/mem_arbiter.sv
// Two-master Wishbone arbiter: the I-cache and D-cache line ports share one memory port.
// A grant is taken from IDLE, held until the line ACK or an abort, and always passes back through IDLE.
module mem_arbiter #(
  parameter int          ROUND_ROBIN    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  // I-cache master
  input  logic         i_cyc,
  input  logic         i_stb,
  input  logic         i_we,
  input  logic [11:0]  i_adr,
  input  logic [127:0] i_dat_m,
  input  logic [15:0]  i_sel,
  output logic         i_ack,
  // D-cache master
  input  logic         d_cyc,
  input  logic         d_stb,
  input  logic         d_we,
  input  logic [11:0]  d_adr,
  input  logic [127:0] d_dat_m,
  input  logic [15:0]  d_sel,
  output logic         d_ack,
  // shared read data back to both masters
  output logic [127:0] dat_s,
  // memory slave
  output logic         m_cyc,
  output logic         m_stb,
  output logic         m_we,
  output logic [11:0]  m_adr,
  output logic [127:0] m_dat_m,
  output logic [15:0]  m_sel,
  input  logic         m_ack,
  input  logic [127:0] m_dat_s,
  // status
  output logic         grant_i,
  output logic         grant_d,
  output logic         timeout_err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int WW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LIMIT = WW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t        r_state;
  logic          r_grant_i;
  logic          r_grant_d;
  logic          r_last_d;
  logic          r_timeout_err;
  logic [WW-1:0] r_wdog;

  logic w_req_i;
  logic w_req_d;
  logic w_pick_i;
  logic w_owner_cyc;

  assign w_req_i = i_cyc & i_stb;
  assign w_req_d = d_cyc & d_stb;
  // On contention, round-robin hands the port to whoever did not complete last; otherwise D wins.
  assign w_pick_i    = w_req_i & (~w_req_d | ((ROUND_ROBIN != 0) & r_last_d));
  assign w_owner_cyc = r_grant_i ? i_cyc : d_cyc;

  // NOTE: state and its registered outputs share one always_ff with non-blocking
  // assignments only, so every flop samples the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_grant_i     <= 1'b0;
      r_grant_d     <= 1'b0;
      r_last_d      <= 1'b1;
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wdog <= '0;
          if (w_pick_i) begin
            r_state   <= GNT_I;
            r_grant_i <= 1'b1;
          end else if (w_req_d) begin
            r_state   <= GNT_D;
            r_grant_d <= 1'b1;
          end
        end
        GNT_I, GNT_D: begin
          if (m_ack) begin
            // Completion wins over a same-cycle drop of CYC.
            r_state   <= IDLE;
            r_grant_i <= 1'b0;
            r_grant_d <= 1'b0;
            r_last_d  <= (r_state == GNT_D);
            r_wdog    <= '0;
          end else begin
            if (r_wdog != '1) r_wdog <= r_wdog + 1'b1;
            if (WD_EN && (r_wdog == WD_LIMIT)) r_timeout_err <= 1'b1;
            if (!w_owner_cyc) begin
              r_state   <= IDLE;
              r_grant_i <= 1'b0;
              r_grant_d <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_grant_i <= 1'b0;
          r_grant_d <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_adr   = '0;
    m_dat_m = '0;
    m_sel   = '0;
    if (r_grant_i) begin
      m_cyc   = i_cyc;
      m_stb   = i_stb;
      m_we    = i_we;
      m_adr   = i_adr;
      m_dat_m = i_dat_m;
      m_sel   = i_sel;
    end else if (r_grant_d) begin
      m_cyc   = d_cyc;
      m_stb   = d_stb;
      m_we    = d_we;
      m_adr   = d_adr;
      m_dat_m = d_dat_m;
      m_sel   = d_sel;
    end
  end

  assign i_ack       = m_ack & r_grant_i;
  assign d_ack       = m_ack & r_grant_d;
  assign dat_s       = m_dat_s;
  assign grant_i     = r_grant_i;
  assign grant_d     = r_grant_d;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: dut_a is round-robin with an 8-cycle watchdog,
// dut_b is fixed-priority with the watchdog disabled; both see the same stimulus.
module tb_mem_arbiter;

  typedef struct {
    logic         is_d;
    logic [11:0]  adr;
    logic         we;
    logic [127:0] wdat;
    logic [127:0] rdat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic i_cyc, i_stb, i_we, d_cyc, d_stb, d_we, m_ack;
  logic [11:0]  i_adr, d_adr;
  logic [127:0] i_dat_m, d_dat_m, m_dat_s;
  logic [15:0]  i_sel, d_sel;

  logic         i_ack_a, d_ack_a, m_cyc_a, m_stb_a, m_we_a, grant_i_a, grant_d_a, timeout_err_a;
  logic         i_ack_b, d_ack_b, m_cyc_b, m_stb_b, m_we_b, grant_i_b, grant_d_b, timeout_err_b;
  logic [11:0]  m_adr_a, m_adr_b;
  logic [127:0] m_dat_m_a, m_dat_m_b, dat_s_a, dat_s_b;
  logic [15:0]  m_sel_a, m_sel_b;

  logic         sel_fp = 1'b0;
  logic         w_i_ack, w_d_ack, w_m_stb, w_m_we;
  logic [11:0]  w_m_adr;
  logic [127:0] w_m_dat_m, w_dat_s;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_m(i_dat_m), .i_sel(i_sel),
    .i_ack(i_ack_a),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_dat_m(d_dat_m), .d_sel(d_sel),
    .d_ack(d_ack_a),
    .dat_s(dat_s_a),
    .m_cyc(m_cyc_a), .m_stb(m_stb_a), .m_we(m_we_a), .m_adr(m_adr_a), .m_dat_m(m_dat_m_a),
    .m_sel(m_sel_a), .m_ack(m_ack), .m_dat_s(m_dat_s),
    .grant_i(grant_i_a), .grant_d(grant_d_a), .timeout_err(timeout_err_a)
  );

  mem_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_m(i_dat_m), .i_sel(i_sel),
    .i_ack(i_ack_b),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_dat_m(d_dat_m), .d_sel(d_sel),
    .d_ack(d_ack_b),
    .dat_s(dat_s_b),
    .m_cyc(m_cyc_b), .m_stb(m_stb_b), .m_we(m_we_b), .m_adr(m_adr_b), .m_dat_m(m_dat_m_b),
    .m_sel(m_sel_b), .m_ack(m_ack), .m_dat_s(m_dat_s),
    .grant_i(grant_i_b), .grant_d(grant_d_b), .timeout_err(timeout_err_b)
  );

  // View of whichever instance the current test is driving against.
  assign w_i_ack   = sel_fp ? i_ack_b   : i_ack_a;
  assign w_d_ack   = sel_fp ? d_ack_b   : d_ack_a;
  assign w_m_stb   = sel_fp ? m_stb_b   : m_stb_a;
  assign w_m_we    = sel_fp ? m_we_b    : m_we_a;
  assign w_m_adr   = sel_fp ? m_adr_b   : m_adr_a;
  assign w_m_dat_m = sel_fp ? m_dat_m_b : m_dat_m_a;
  assign w_dat_s   = sel_fp ? dat_s_b   : dat_s_a;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_d, input logic [11:0] adr, input logic we,
                      input logic [127:0] wdat, input logic [127:0] rdat);
    exp_t e;
    e.is_d = is_d; e.adr = adr; e.we = we; e.wdat = wdat; e.rdat = rdat;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_dat_m = '0; i_sel = '0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_dat_m = '0; d_sel = '0;
    m_ack = 0; m_dat_s = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Memory model: wait (bounded) for a strobe, then ACK lat cycles into the grant.
  task automatic mem_respond(input int lat, input logic [127:0] rdat);
    int n = 0;
    while (!w_m_stb && n < 50) begin
      tick();
      n++;
    end
    check("m_stb_wait", w_m_stb, 1'b1);
    repeat (lat - 1) tick();
    m_ack = 1'b1;
    m_dat_s = rdat;
    tick();
    m_ack = 1'b0;
  endtask

  // Monitor: every ACK the active DUT presents is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && (w_i_ack || w_d_ack)) begin
      check("ack_expected", (sb.size() != 0), 1'b1);
      check("ack_onehot", (w_i_ack & w_d_ack), 1'b0);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("ack_master", w_d_ack, e.is_d);
        check("ack_adr", w_m_adr, e.adr);
        check("ack_we", w_m_we, e.we);
        check("ack_wdat", w_m_dat_m, e.wdat);
        check("ack_dat_s", w_dat_s, e.rdat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    do_reset();
    check("rst_grant_i", grant_i_a, 1'b0);
    check("rst_grant_d", grant_d_a, 1'b0);
    check("rst_m_cyc", m_cyc_a, 1'b0);
    check("rst_timeout", timeout_err_a, 1'b0);

    // Reset asserted in the middle of a D grant, with an ACK arriving at the same time.
    d_cyc = 1; d_stb = 1; d_adr = 12'h123; d_sel = 16'hffff;
    tick();
    check("pre_rst_grant_d", grant_d_a, 1'b1);
    #2;
    rst_n = 1'b0;
    m_ack = 1'b1;
    #1;
    check("midrst_m_cyc", m_cyc_a, 1'b0);
    check("midrst_m_stb", m_stb_a, 1'b0);
    check("midrst_grant_d", grant_d_a, 1'b0);
    check("midrst_d_ack", d_ack_a, 1'b0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("postrst_grant_d", grant_d_a, 1'b0);
    check("postrst_m_cyc", m_cyc_a, 1'b0);

    // I-only read of line 0A3, ACK on the fourth grant cycle.
    i_cyc = 1; i_stb = 1; i_adr = 12'h0A3; i_sel = 16'hffff;
    push(1'b0, 12'h0A3, 1'b0, '0, 128'hCAFE_0000_0000_0000_0000_0000_0000_00A3);
    tick();
    check("ionly_grant_i", grant_i_a, 1'b1);
    check("ionly_grant_d", grant_d_a, 1'b0);
    check("ionly_m_stb", m_stb_a, 1'b1);
    check("ionly_m_adr", m_adr_a, 12'h0A3);
    tick();
    tick();
    tick();
    m_ack = 1'b1;
    m_dat_s = 128'hCAFE_0000_0000_0000_0000_0000_0000_00A3;
    #1;
    check("ionly_d_ack", d_ack_a, 1'b0);
    tick();
    m_ack = 1'b0;
    i_cyc = 0; i_stb = 0;
    check("ionly_release", grant_i_a, 1'b0);

    // Spurious ACK while IDLE must not be forwarded.
    m_ack = 1'b1;
    #1;
    check("spur_i_ack", i_ack_a, 1'b0);
    check("spur_d_ack", d_ack_a, 1'b0);
    tick();
    m_ack = 1'b0;

    // Round-robin contention from reset exit: I, D, I.
    do_reset();
    i_cyc = 1; i_stb = 1; i_adr = 12'h111; i_sel = 16'hffff;
    d_cyc = 1; d_stb = 1; d_adr = 12'h222; d_sel = 16'hffff;
    push(1'b0, 12'h111, 1'b0, '0, 128'h1);
    push(1'b1, 12'h222, 1'b0, '0, 128'h2);
    push(1'b0, 12'h111, 1'b0, '0, 128'h3);
    mem_respond(3, 128'h1);
    mem_respond(3, 128'h2);
    mem_respond(3, 128'h3);
    idle_inputs();
    tick();
    tick();
    check("rr_sb_drained", sb.size(), 0);

    // Fixed priority: D wins every arbitration while it keeps requesting.
    sel_fp = 1'b1;
    do_reset();
    i_cyc = 1; i_stb = 1; i_adr = 12'h555; i_sel = 16'hffff;
    d_cyc = 1; d_stb = 1; d_adr = 12'h666; d_sel = 16'hffff;
    push(1'b1, 12'h666, 1'b0, '0, 128'h11);
    push(1'b1, 12'h666, 1'b0, '0, 128'h12);
    push(1'b1, 12'h666, 1'b0, '0, 128'h13);
    mem_respond(2, 128'h11);
    mem_respond(2, 128'h12);
    mem_respond(2, 128'h13);
    d_cyc = 0; d_stb = 0;
    push(1'b0, 12'h555, 1'b0, '0, 128'h14);
    mem_respond(2, 128'h14);
    idle_inputs();
    tick();
    tick();
    check("fp_sb_drained", sb.size(), 0);
    sel_fp = 1'b0;

    // D write to FFF, then aborted by dropping CYC.
    do_reset();
    d_cyc = 1; d_stb = 1; d_we = 1; d_adr = 12'hFFF; d_sel = 16'hffff; d_dat_m = {16{8'h55}};
    tick();
    check("dwr_grant_d", grant_d_a, 1'b1);
    check("dwr_m_we", m_we_a, 1'b1);
    check("dwr_m_adr", m_adr_a, 12'hFFF);
    check("dwr_m_dat_m", m_dat_m_a, {16{8'h55}});
    check("dwr_m_sel", m_sel_a, 16'hffff);
    d_cyc = 0; d_stb = 0;
    tick();
    check("dabort_grant_d", grant_d_a, 1'b0);
    check("dabort_m_cyc", m_cyc_a, 1'b0);
    check("dabort_m_we", m_we_a, 1'b0);
    idle_inputs();
    // Abort of I leaves last=D, so the next contention still goes to I.
    i_cyc = 1; i_stb = 1; i_adr = 12'h333;
    tick();
    check("iabort_grant_i", grant_i_a, 1'b1);
    i_cyc = 0; i_stb = 0;
    tick();
    check("iabort_release", grant_i_a, 1'b0);
    i_cyc = 1; i_stb = 1; i_adr = 12'h333;
    d_cyc = 1; d_stb = 1; d_adr = 12'h444;
    push(1'b0, 12'h333, 1'b0, '0, 128'h21);
    mem_respond(2, 128'h21);
    idle_inputs();
    tick();
    tick();
    check("abort_sb_drained", sb.size(), 0);

    // Watchdog: wdog==7 at the end of grant cycle 8 sets the flag, visible from cycle 9.
    do_reset();
    i_cyc = 1; i_stb = 1; i_adr = 12'h0C0;
    tick();
    repeat (7) tick();
    check("wd_cycle8", timeout_err_a, 1'b0);
    tick();
    check("wd_cycle9", timeout_err_a, 1'b1);
    check("wd_still_granted", grant_i_a, 1'b1);
    check("wd_disabled_b", timeout_err_b, 1'b0);
    push(1'b0, 12'h0C0, 1'b0, '0, 128'h31);
    m_ack = 1'b1;
    m_dat_s = 128'h31;
    tick();
    idle_inputs();
    tick();
    check("wd_sticky", timeout_err_a, 1'b1);
    check("wd_release", grant_i_a, 1'b0);
    check("final_sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
